uart_tx_arbiter: RTL and testbench

Shares one UART transmit line, and the baud-tick generator behind it, among N_REQ byte requesters. Arbitration is round-robin. The block accepts one byte per frame and drives bps_start to the baud generator. It serializes start/data/stop bits on each clk_bps mid-bit pulse it receives back. It sits between the application byte sources and the board TX pin, next to the baud-rate generator.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_arbiter_rr_arbiter.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART framing constants and FSM state type for the arbitrated transmitter.
// Build with UART_PARITY_EN defined to add an even-parity bit (8E1 framing).
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int BIT_CNT_W   = 4;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Index of the last data bit within the frame; bit 0 is the start bit.
  localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = 4'd8;

`ifdef UART_PARITY_EN
  localparam logic [BIT_CNT_W-1:0] PARITY_BIT = 4'd9;
  localparam logic [BIT_CNT_W-1:0] FRAME_BITS = 4'd11;
`else
  localparam logic [BIT_CNT_W-1:0] FRAME_BITS = 4'd10;
`endif

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
// Produces a one-hot grant, its index, and a valid flag.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             valid
);

  // NOTE: every output gets a default before the search loop, so no latch is inferred.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = (int'(ptr) + off) % N_REQ;
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin shared UART transmitter: grants one requester per frame and serializes
// its byte on clk_bps pulses. Define UART_PARITY_EN for an even-parity bit before stop.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req,
  input  logic [UART_DATA_W*N_REQ-1:0] data,
  output logic [N_REQ-1:0]             ack,
  input  logic                         clk_bps,
  output logic                         bps_start,
  output logic                         tx,
  output logic                         busy,
  output logic [ID_W-1:0]              grant_id
);

  state_t                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic                   tx_d, bps_start_d, busy_d;
  logic [N_REQ-1:0]       ack_d;
  logic [ID_W-1:0]        grant_id_d;

  logic [N_REQ-1:0]       arb_grant;
  logic [ID_W-1:0]        arb_idx;
  logic                   arb_valid;

`ifdef UART_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .req       (req),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    tx_d        = tx;
    bps_start_d = bps_start;
    busy_d      = busy;
    ack_d       = '0;
    grant_id_d  = grant_id;
`ifdef UART_PARITY_EN
    parity_d    = parity_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          shift_d     = data[UART_DATA_W*int'(arb_idx) +: UART_DATA_W];
`ifdef UART_PARITY_EN
          parity_d    = ^data[UART_DATA_W*int'(arb_idx) +: UART_DATA_W];
`endif
          ack_d       = arb_grant;
          grant_id_d  = arb_idx;
          bps_start_d = 1'b1;
          busy_d      = 1'b1;
          bit_cnt_d   = '0;
          state_d     = SEND;
        end
      end

      SEND: begin
        if (clk_bps) begin
          if (bit_cnt_q == FRAME_BITS) begin
            // Dropping bps_start here lets the baud counter restart for the next frame.
            bps_start_d = 1'b0;
            busy_d      = 1'b0;
            tx_d        = STOP_BIT;
            ptr_d       = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            state_d     = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == '0) begin
              tx_d = START_BIT;
            end else if (bit_cnt_q <= LAST_DATA_BIT) begin
              tx_d    = shift_q[0];
              shift_d = shift_q >> 1;
`ifdef UART_PARITY_EN
            end else if (bit_cnt_q == PARITY_BIT) begin
              tx_d = parity_q;
`endif
            end else begin
              tx_d = STOP_BIT;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every register
  // samples the values computed in the previous cycle regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      tx        <= STOP_BIT;
      bps_start <= 1'b0;
      busy      <= 1'b0;
      ack       <= '0;
      grant_id  <= '0;
`ifdef UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      tx        <= tx_d;
      bps_start <= bps_start_d;
      busy      <= busy_d;
      ack       <= ack_d;
      grant_id  <= grant_id_d;
`ifdef UART_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter: expected grant order and tx bits are
// queued by the stimulus and popped as the DUT acks and serializes each frame.
module tb_uart_tx_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
`ifdef UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] data;
  logic [N_REQ-1:0]   ack;
  logic               clk_bps;
  logic               bps_start;
  logic               tx;
  logic               busy;
  logic [ID_W-1:0]    grant_id;

  int   vectors     = 0;
  int   miscompares = 0;
  int   grant_q[$];
  logic bit_q[$];
  logic [7:0] byte_of [N_REQ];

  uart_tx_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data      (data),
    .ack       (ack),
    .clk_bps   (clk_bps),
    .bps_start (bps_start),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #10 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
`ifdef UART_PARITY_EN
    if (pos == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic load_data();
    for (int i = 0; i < N_REQ; i++) data[8*i +: 8] = byte_of[i];
  endtask

  task automatic pulse();
    clk_bps = 1'b1;
    tick();
    clk_bps = 1'b0;
  endtask

  task automatic do_reset();
    req     = '0;
    clk_bps = 1'b0;
    rst_n   = 1'b0;
    #25;
    check("rst_tx", tx, 1);
    check("rst_bps_start", bps_start, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_grant_id", grant_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_ack(output int cycles);
    cycles = 0;
    while (ack == '0 && cycles < 20) begin
      tick();
      cycles++;
    end
    check("ack_seen", {31'd0, |ack}, 1);
  endtask

  // Waits for the next grant, compares it with the scoreboard, then clocks the frame out.
  task automatic run_frame(input logic drop, output int lat);
    int         exp_id;
    logic [7:0] b;
    wait_ack(lat);
    if (ack == '0 || grant_q.size() == 0) return;
    exp_id = grant_q.pop_front();
    check("ack_onehot", ack, 32'(1) << exp_id);
    check("grant_id", grant_id, exp_id);
    check("grant_bps_start", bps_start, 1);
    check("grant_busy", busy, 1);
    b = byte_of[exp_id];
    for (int p = 0; p < FB; p++) bit_q.push_back(frame_bit(b, p));
    if (drop) req[exp_id] = 1'b0;
    tick();
    check("ack_one_cycle", ack, 0);
    for (int p = 0; p <= FB; p++) begin
      pulse();
      if (p < FB) begin
        check("tx_bit", tx, bit_q.pop_front());
        check("bps_hold", bps_start, 1);
        check("ack_in_send", ack, 0);
        tick();
        tick();
      end else begin
        check("bps_release", bps_start, 0);
        check("busy_release", busy, 0);
        check("tx_idle", tx, 1);
      end
    end
  endtask

  initial begin
    int         lat;
    logic [7:0] b;
    byte_of[0] = 8'h3C;
    byte_of[1] = 8'hA5;
    byte_of[2] = 8'h5A;
    byte_of[3] = 8'hC3;
    load_data();

    // Single requester 1 with byte 0xA5, including grant latency.
    do_reset();
    req = 4'b0010;
    check("ack_before_edge", ack, 0);
    grant_q.push_back(1);
    run_frame(1'b1, lat);
    check("ack_latency", lat, 1);

    // All four requesting, each dropping after its ack: strict 0,1,2,3 order.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) grant_q.push_back(i);
    for (int i = 0; i < 4; i++) run_frame(1'b1, lat);
    check("rr_gap_latency", lat, 1);

    // Requesters 0 and 2 held continuously: alternate 0,2,0,2.
    req = 4'b0101;
    grant_q.push_back(0);
    grant_q.push_back(2);
    grant_q.push_back(0);
    grant_q.push_back(2);
    for (int i = 0; i < 4; i++) run_frame(1'b0, lat);
    check("scoreboard_empty", grant_q.size(), 0);

    // Abort a frame from requester 2 after four baud pulses (pointer is 3 beforehand).
    req = 4'b0100;
    wait_ack(lat);
    check("abort_ack", ack, 4'b0100);
    check("abort_grant", grant_id, 2);
    req = '0;
    b = byte_of[2];
    tick();
    for (int p = 0; p < 4; p++) begin
      pulse();
      check("abort_tx_bit", tx, frame_bit(b, p));
      tick();
    end
    #5;
    rst_n = 1'b0;
    #1;
    check("abort_tx", tx, 1);
    check("abort_bps_start", bps_start, 0);
    check("abort_busy", busy, 0);
    check("abort_ack_clear", ack, 0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1001;
    grant_q.push_back(0);
    grant_q.push_back(3);
    run_frame(1'b1, lat);
    run_frame(1'b1, lat);

    // Baud pulses while idle are ignored.
    req = '0;
    tick();
    for (int p = 0; p < 5; p++) begin
      pulse();
      check("idle_tx", tx, 1);
      check("idle_busy", busy, 0);
      check("idle_ack", ack, 0);
      check("idle_bps_start", bps_start, 0);
      tick();
    end

`ifdef UART_PARITY_EN
    // 8E1 frame for 0x07: parity bit 1 before the stop bit.
    byte_of[1] = 8'h07;
    load_data();
    req = 4'b0010;
    grant_q.push_back(1);
    run_frame(1'b1, lat);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
